// File: rtl/uart_arb_pkg.sv
// Shared types and default constants for the uart_tx byte-stream arbiter.
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int DEF_N_REQ       = 2;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_TIMEOUT_CYC = 1000000;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin search: first set request strictly after last_idx, wrapping.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_idx,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;

  // Rotate so that bit 0 of rot is the requester right after last_idx.
  assign dbl = {req, req} >> (int'(last_idx) + 1);
  assign rot = dbl[N_REQ-1:0];

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(last_idx) + 1 + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx byte stream among N_REQ sources.
// Valid/ready: a beat moves on a rising edge where valid and ready are both high; valid may drop freely.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        s_tvalid,
  output logic [N_REQ-1:0]        s_tready,
  input  logic [N_REQ*DATA_W-1:0] s_tdata,
  input  logic [N_REQ-1:0]        s_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [DATA_W-1:0]       m_tdata,
  output logic                    m_tlast,
  output logic [N_REQ-1:0]        o_grant,
  output logic                    o_timeout
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [IDX_W-1:0] last_idx, last_nxt;
  logic [CNT_W-1:0] stall_cnt, stall_nxt;
  logic             timeout_nxt;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             own_valid, own_last, own_hs;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req      (s_tvalid),
    .last_idx (last_idx),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  assign own_valid = s_tvalid[owner];
  assign own_last  = s_tlast[owner];
  assign own_hs    = own_valid & m_tready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      owner     <= '0;
      last_idx  <= IDX_W'(N_REQ - 1);
      stall_cnt <= '0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      last_idx  <= last_nxt;
      stall_cnt <= stall_nxt;
      o_timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    last_nxt    = last_idx;
    stall_nxt   = stall_cnt;
    timeout_nxt = 1'b0;
    m_tvalid    = 1'b0;
    m_tdata     = '0;
    m_tlast     = 1'b0;
    s_tready    = '0;
    o_grant     = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          owner_nxt = pick_idx;
          stall_nxt = '0;
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        m_tvalid        = own_valid;
        m_tdata         = s_tdata[DATA_W*int'(owner) +: DATA_W];
        m_tlast         = own_last;
        s_tready[owner] = m_tready;
        o_grant[owner]  = 1'b1;
        if (own_hs) begin
          stall_nxt = '0;
          if (own_last) begin
            state_nxt = IDLE;
            last_nxt  = owner;
          end
        end else if (!own_valid && TIMEOUT_CYC != 0) begin
          // Only a silent owner stalls; sink back-pressure never counts.
          stall_nxt = stall_cnt + CNT_W'(1);
          if (stall_nxt == TO_VAL) begin
            state_nxt   = IDLE;
            last_nxt    = owner;
            timeout_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester drivers, expected queues, negedge monitor.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 100;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   s_tvalid, s_tready, s_tlast, o_grant;
  logic [N*W-1:0] s_tdata;
  logic           m_tvalid, m_tready, m_tlast, o_timeout;
  logic [W-1:0]   m_tdata;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .s_tlast   (s_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .o_grant   (o_grant),
    .o_timeout (o_timeout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: sim time exceeded, got running want finished");
    $fatal(1, "watchdog");
  end

  // ---------------- shared state ----------------
  logic [W:0] tx_q  [N][$];  // {last, data} beats still to be offered by each requester
  logic [W:0] exp_q [N][$];  // expected beats per requester
  int         n_cmp = 0;
  int         n_err = 0;
  bit         rand_gap = 1'b0;
  int         rdy_mode = 1;   // 0: low, 1: high, 2: random
  int         cyc = 0;
  int         obs_idx[$];
  int         obs_cyc[$];
  logic [W-1:0] obs_dat[$];
  int         to_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- drivers ----------------
  for (genvar g = 0; g < N; g++) begin : g_drv
    logic         v = 1'b0;
    logic         l = 1'b0;
    logic [W-1:0] d = '0;
    assign s_tvalid[g]       = v;
    assign s_tlast[g]        = l;
    assign s_tdata[g*W +: W] = d;
    initial begin
      bit hs;
      forever begin
        @(negedge clk);
        hs = v && s_tready[g];
        @(posedge clk);
        #1;
        if (hs && tx_q[g].size() > 0) void'(tx_q[g].pop_front());
        v = (tx_q[g].size() > 0) && (!rand_gap || $urandom_range(0, 3) != 0);
        {l, d} = (tx_q[g].size() > 0) ? tx_q[g][0] : '0;
      end
    end
  end

  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b0;
        1:       m_tready = 1'b1;
        default: m_tready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  task automatic push_beat(input int r, input logic last, input logic [W-1:0] b);
    tx_q[r].push_back({last, b});
    exp_q[r].push_back({last, b});
  endtask

  task automatic push_str(input int r, input string s);
    for (int i = 0; i < s.len(); i++) push_beat(r, i == s.len() - 1, s[i]);
  endtask

  task automatic push_rand(input int r, input int len);
    for (int i = 0; i < len; i++) push_beat(r, i == len - 1, W'($urandom_range(0, 255)));
  endtask

  task automatic wait_obs(input string name, input int n, input int budget);
    for (int i = 0; i < budget && obs_idx.size() < n; i++) @(posedge clk);
    check(name, 32'(obs_idx.size() >= n), 32'd1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int left;
    for (int i = 0; i < budget; i++) begin
      left = 0;
      for (int r = 0; r < N; r++) left += exp_q[r].size() + tx_q[r].size();
      if (left == 0) break;
      @(posedge clk);
    end
    check(name, 32'(left), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int         idx;
    logic [W:0] e;
    bit         in_pkt;
    int         pkt_own;
    in_pkt  = 1'b0;
    pkt_own = 0;
    forever begin
      @(negedge clk);
      cyc++;
      check("grant_onehot0", 32'($onehot0(o_grant)), 32'd1);
      if (o_timeout) to_cyc.push_back(cyc);
      if (!rstn || o_timeout) in_pkt = 1'b0;
      if (m_tvalid && m_tready) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (o_grant[i]) idx = i;
        check("beat_granted", 32'($onehot(o_grant)), 32'd1);
        check("beat_s_tready", 32'(s_tready), 32'(1 << idx));
        if (in_pkt) check("pkt_contiguous", 32'(idx), 32'(pkt_own));
        check("beat_expected", 32'(exp_q[idx].size() > 0), 32'd1);
        if (exp_q[idx].size() > 0) begin
          e = exp_q[idx].pop_front();
          check($sformatf("beat_req%0d", idx), 32'({m_tlast, m_tdata}), 32'(e));
        end
        in_pkt  = !m_tlast;
        pkt_own = idx;
        obs_idx.push_back(idx);
        obs_cyc.push_back(cyc);
        obs_dat.push_back(m_tdata);
      end
    end
  end

  // ---------------- directed sequences ----------------
  initial begin : stim
    int           base, to_base, hs_c;
    logic [W-1:0] exp034 [6];
    int           gnt034 [6];
    int           seq035 [8];
    exp034 = '{8'h41, 8'h42, 8'h0A, 8'h63, 8'h64, 8'h0A};
    gnt034 = '{0, 0, 0, 1, 1, 1};
    seq035 = '{1, 1, 1, 0, 0, 1, 1, 1};

    // reset state
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_tdata), 32'd0);
    check("rst_m_tlast", 32'(m_tlast), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_o_grant", 32'(o_grant), 32'd0);
    check("rst_o_timeout", 32'(o_timeout), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // two simultaneous packets: requester 0 first, one bubble between
    base = obs_idx.size();
    push_str(0, "AB\n");
    push_str(1, "cd\n");
    wait_drain("drain_034", 200);
    wait_obs("obs_034", base + 6, 10);
    for (int i = 0; i < 6; i++) begin
      if (base + i < obs_idx.size()) begin
        check($sformatf("order034_data%0d", i), 32'(obs_dat[base+i]), 32'(exp034[i]));
        check($sformatf("order034_grant%0d", i), 32'(obs_idx[base+i]), 32'(gnt034[i]));
      end
    end
    if (base + 5 < obs_cyc.size()) begin
      check("gap034_inpkt", 32'(obs_cyc[base+1] - obs_cyc[base]), 32'd1);
      check("gap034_bubble", 32'(obs_cyc[base+3] - obs_cyc[base+2]), 32'd2);
    end

    // no preemption: requester 0 arrives mid-packet of requester 1
    base = obs_idx.size();
    push_str(1, "ef\n");
    push_str(1, "gh\n");
    wait_obs("obs_035_first", base + 1, 50);
    push_str(0, "Z\n");
    wait_drain("drain_035", 200);
    for (int i = 0; i < 8; i++)
      if (base + i < obs_idx.size())
        check($sformatf("order035_%0d", i), 32'(obs_idx[base+i]), 32'(seq035[i]));

    // long sink back-pressure never times out
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    base    = obs_idx.size();
    to_base = to_cyc.size();
    push_str(2, "Q!\n");
    repeat (5000) @(posedge clk);
    check("bp_no_beats", 32'(obs_idx.size()), 32'(base));
    check("bp_no_timeout", 32'(to_cyc.size()), 32'(to_base));
    check("bp_grant_held", 32'(o_grant), 32'b0100);
    rdy_mode = 1;
    wait_drain("drain_036", 100);
    check("bp_beats_after", 32'(obs_idx.size()), 32'(base + 3));

    // silent owner: timeout releases, pending requester 3 granted next
    base    = obs_idx.size();
    to_base = to_cyc.size();
    push_beat(0, 1'b0, 8'h55);
    wait_obs("obs_037_first", base + 1, 50);
    hs_c = (obs_cyc.size() > base) ? obs_cyc[base] : 0;
    push_str(3, "T\n");
    for (int i = 0; i < 300 && to_cyc.size() == to_base; i++) @(posedge clk);
    check("to_pulse_seen", 32'(to_cyc.size()), 32'(to_base + 1));
    // pulse rises on the 100th edge after the accepting edge
    if (to_cyc.size() > to_base) check("to_latency", 32'(to_cyc[to_base] - hs_c), 32'd101);
    wait_drain("drain_037", 100);
    check("to_single_pulse", 32'(to_cyc.size()), 32'(to_base + 1));
    if (base + 1 < obs_idx.size()) check("to_next_owner", 32'(obs_idx[base+1]), 32'd3);

    // asynchronous reset mid-packet
    base = obs_idx.size();
    push_str(1, "WXYZ");
    wait_obs("obs_038_first", base + 1, 50);
    @(posedge clk);
    #2;
    check("prerst_grant", 32'(o_grant), 32'b0010);
    rstn = 1'b0;
    #1;
    check("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("midrst_s_tready", 32'(s_tready), 32'd0);
    check("midrst_o_grant", 32'(o_grant), 32'd0);
    exp_q[1].delete();
    tx_q[1].delete();
    push_str(0, "r0\n");
    push_str(1, "r1\n");
    repeat (3) @(posedge clk);
    @(negedge clk);
    base = obs_idx.size();
    rstn = 1'b1;
    wait_drain("drain_038", 100);
    if (base + 3 < obs_idx.size()) begin
      check("postrst_first", 32'(obs_idx[base]), 32'd0);
      check("postrst_second", 32'(obs_idx[base+3]), 32'd1);
    end

    // random valid gaps and ready, four requesters
    rand_gap = 1'b1;
    rdy_mode = 2;
    for (int p = 0; p < 5; p++)
      for (int r = 0; r < N; r++) push_rand(r, $urandom_range(1, 5));
    wait_drain("drain_039", 20000);
    rand_gap = 1'b0;
    rdy_mode = 1;
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, byte width per beat.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000000, stall cycles before forced release; 0 disables timeout.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port s_tvalid  input  N_REQ  per-requester beat valid.
REQ-007 SHALL have port s_tready  output  N_REQ  per-requester beat accept.
REQ-008 SHALL have port s_tdata  input  N_REQ*DATA_W  packed bytes; requester i at bits [DATA_W*i +: DATA_W].
REQ-009 SHALL have port s_tlast  input  N_REQ  per-requester end-of-packet marker.
REQ-010 SHALL have port m_tvalid  output  1  beat valid toward uart_tx i_tvalid.
REQ-011 SHALL have port m_tready  input  1  beat accept from uart_tx i_tready.
REQ-012 SHALL have port m_tdata  output  DATA_W  byte toward uart_tx i_tdata.
REQ-013 SHALL have port m_tlast  output  1  end-of-packet toward uart_tx i_tlast.
REQ-014 SHALL have port o_grant  output  N_REQ  one-hot current owner; all-zero when idle.
REQ-015 SHALL have port o_timeout  output  1  one-cycle pulse on forced release.

Function
REQ-016 SHALL share the uart_tx byte stream among requesters with packet-granular round-robin arbitration.
REQ-017 SHALL implement FSM states IDLE and LOCK.
REQ-018 IDLE: m_tvalid=0, m_tdata=0, m_tlast=0, s_tready all 0, o_grant=0.
REQ-019 IDLE with any s_tvalid high: SHALL pick the first requester with s_tvalid high, searching from last_idx+1 upward modulo N_REQ; register it as owner and enter LOCK next cycle.
REQ-020 last_idx SHALL reset to N_REQ-1, so requester 0 has first priority after reset.
REQ-021 LOCK: m_tvalid, m_tdata and m_tlast SHALL combinationally follow the owner; s_tready[owner]=m_tready; all other s_tready=0.
REQ-022 LOCK: a handshake (s_tvalid[owner] & m_tready) with s_tlast[owner]=1 SHALL return to IDLE next cycle and set last_idx=owner.
REQ-023 The owner dropping s_tvalid mid-packet SHALL be legal; the grant SHALL be held and m_tvalid SHALL follow s_tvalid[owner].
REQ-024 Stall counter, width $clog2(TIMEOUT_CYC+1):
  - increments each LOCK cycle with s_tvalid[owner]=0;
  - clears on any owner handshake and on entering LOCK.
REQ-025 Stall counter reaching TIMEOUT_CYC (nonzero) SHALL:
  - return to IDLE next cycle;
  - pulse o_timeout for one cycle;
  - set last_idx=owner.
REQ-026 Sink back-pressure (m_tready=0 while s_tvalid[owner]=1) SHALL never advance the stall counter.
REQ-027 Every packet end SHALL pass through one IDLE cycle, so back-to-back packets see exactly one bubble cycle.
REQ-028 Requests arriving during LOCK SHALL wait; no preemption except by timeout.
REQ-029 Throughput in LOCK SHALL be one beat per cycle when s_tvalid and m_tready are both high.

Reset
REQ-030 rstn low SHALL asynchronously force:
  - state=IDLE, owner=0, last_idx=N_REQ-1;
  - stall counter=0, o_timeout=0;
  - all outputs to their IDLE values, including mid-packet.
REQ-031 After rstn rises, the first arbitration SHALL occur no earlier than the first rising clk edge.

Structure
REQ-032 Package uart_arb_pkg SHALL hold the state enum (IDLE, LOCK) and the default parameter constants.
REQ-033 Round-robin search SHALL be a combinational sub-module uart_rr_pick, with inputs req and last_idx and outputs found and idx.

Verification
REQ-034 Reset, then s_tvalid=2'b11 with 3-byte packets "AB\n" and "cd\n" and m_tready=1 -> m_tdata order 41,42,0A,63,64,0A; o_grant 01 then 10; one idle cycle between packets.
REQ-035 Requester 1 streams packets continuously and requester 0 raises valid mid-packet -> requester 1 finishes its packet, then requester 0 is granted next.
REQ-036 m_tready held 0 for 5000 cycles with TIMEOUT_CYC=100 -> no o_timeout; all beats delivered once m_tready rises.
REQ-037 Owner drops s_tvalid after 1 byte with TIMEOUT_CYC=100 -> o_timeout pulses exactly 100 cycles later; the pending requester is then granted.
REQ-038 rstn asserted mid-packet -> m_tvalid, s_tready and o_grant go 0 immediately; after release, requester 0 wins the first arbitration.
REQ-039 Randomized valid and ready with 4 requesters -> every packet arrives intact and contiguous; the scoreboard matches per requester; o_grant is always one-hot or zero.
